// File: rtl/sar_conv_ctrl.sv
// sar_conv_ctrl: host-triggered, back-pressured conversion sequencer for a 6-bit SAR ADC.
// Optional build macro SAR_CTRL_AVG_EN: each start runs 4 conversions and returns the rounded mean.
module sar_conv_ctrl #(
  parameter int unsigned SAMPLE_CYCLES = 2,
  parameter int unsigned SETTLE_CYCLES = 1,
  localparam int unsigned NBITS = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  input  logic             comp_in,
  output logic             comp_en,
  output logic             sample,
  output logic [NBITS-1:0] sw,
  output logic [NBITS-1:0] swb,
  output logic [NBITS-1:0] result,
  output logic             result_valid,
  input  logic             result_ready
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned IDX_W = 3;
  localparam logic [CNT_W-1:0] SAMPLE_LOAD = CNT_W'(SAMPLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD =
      (SETTLE_CYCLES > 0) ? CNT_W'(SETTLE_CYCLES - 1) : '0;
  localparam logic [IDX_W-1:0] MSB_IDX = IDX_W'(NBITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SAMPLE,
    S_SETTLE,
    S_COMPARE,
    S_HOLD
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] bit_q, bit_d;
  logic [NBITS-1:0] r_q, r_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [NBITS-1:0] r_upd;
  logic [NBITS-1:0] final_code;
  logic [NBITS-1:0] result_d;
  logic             result_valid_d;
  logic             busy_d;
  logic             sample_d;
  logic             comp_en_d;
  logic [NBITS-1:0] sw_d;
  logic             free;

  // Current decision register with the bit under test replaced by the comparator output
  assign r_upd = r_q | (NBITS'(comp_in) << bit_q);
  assign free  = ~result_valid | result_ready;

`ifdef SAR_CTRL_AVG_EN
  logic [1:0] conv_q, conv_d;
  logic [7:0] sum_q, sum_d;
  logic [7:0] avg_total;

  // 4 codes of at most 63 plus rounding fit in 8 bits
  assign avg_total  = sum_q + 8'(r_upd) + 8'd2;
  assign final_code = NBITS'(avg_total >> 2);
`else
  assign final_code = r_upd;
`endif

  // Next-state, datapath and registered-output decode
  always_comb begin
    state_d        = state_q;
    bit_d          = bit_q;
    r_d            = r_q;
    cnt_d          = cnt_q;
    result_d       = result;
    result_valid_d = result_valid & ~result_ready;
`ifdef SAR_CTRL_AVG_EN
    conv_d         = conv_q;
    sum_d          = sum_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_SAMPLE;
          bit_d   = MSB_IDX;
          r_d     = '0;
          cnt_d   = SAMPLE_LOAD;
`ifdef SAR_CTRL_AVG_EN
          conv_d  = '0;
          sum_d   = '0;
`endif
        end
      end

      S_SAMPLE: begin
        if (cnt_q == '0) begin
          state_d = (SETTLE_CYCLES == 0) ? S_COMPARE : S_SETTLE;
          cnt_d   = SETTLE_LOAD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      S_SETTLE: begin
        if (cnt_q == '0) begin
          state_d = S_COMPARE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      S_COMPARE: begin
        r_d = r_upd;
        if (bit_q != '0) begin
          bit_d   = bit_q - IDX_W'(1);
          state_d = (SETTLE_CYCLES == 0) ? S_COMPARE : S_SETTLE;
          cnt_d   = SETTLE_LOAD;
        end
`ifdef SAR_CTRL_AVG_EN
        else if (conv_q != 2'd3) begin
          // Chain straight into the next conversion of the group
          conv_d  = conv_q + 2'd1;
          sum_d   = sum_q + 8'(r_upd);
          state_d = S_SAMPLE;
          bit_d   = MSB_IDX;
          r_d     = '0;
          cnt_d   = SAMPLE_LOAD;
        end
`endif
        else if (free) begin
          result_d       = final_code;
          result_valid_d = 1'b1;
          state_d        = S_IDLE;
        end else begin
          // Park the finished code in the decision register until the consumer frees the slot
          r_d     = final_code;
          state_d = S_HOLD;
        end
      end

      S_HOLD: begin
        if (free) begin
          result_d       = r_q;
          result_valid_d = 1'b1;
          state_d        = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    busy_d    = (state_d != S_IDLE);
    sample_d  = (state_d == S_SAMPLE);
    comp_en_d = (state_d == S_COMPARE);
    case (state_d)
      S_SAMPLE:            sw_d = '1;
      S_SETTLE, S_COMPARE: sw_d = r_d | (NBITS'(1) << bit_d);
      default:             sw_d = '0;
    endcase
  end

  // State, datapath and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      bit_q        <= MSB_IDX;
      r_q          <= '0;
      cnt_q        <= '0;
      busy         <= 1'b0;
      sample       <= 1'b0;
      comp_en      <= 1'b0;
      sw           <= '0;
      swb          <= '1;
      result       <= '0;
      result_valid <= 1'b0;
`ifdef SAR_CTRL_AVG_EN
      conv_q       <= '0;
      sum_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      bit_q        <= bit_d;
      r_q          <= r_d;
      cnt_q        <= cnt_d;
      busy         <= busy_d;
      sample       <= sample_d;
      comp_en      <= comp_en_d;
      sw           <= sw_d;
      swb          <= ~sw_d;
      result       <= result_d;
      result_valid <= result_valid_d;
`ifdef SAR_CTRL_AVG_EN
      conv_q       <= conv_d;
      sum_q        <= sum_d;
`endif
    end
  end

endmodule

// File: tb/tb_sar_conv_ctrl.sv
// Self-checking bench for sar_conv_ctrl: ideal comparator model, scoreboard of expected codes.
`timescale 1ns/1ps
module tb_sar_conv_ctrl;

  localparam int L  = 2 + 6 * (1 + 1);
  localparam int LF = 1 + 6 * (0 + 1);
`ifdef SAR_CTRL_AVG_EN
  localparam int CONV = 4;
`else
  localparam int CONV = 1;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, comp_in, comp_en, sample, busy, result_valid, result_ready;
  logic [5:0] sw, swb, result, vin, swn;

  logic       f_rst, f_start, f_comp_in, f_comp_en, f_sample, f_busy, f_valid, f_ready;
  logic [5:0] f_sw, f_swb, f_result, f_vin, f_swn;

  assign comp_in   = (vin >= sw);
  assign f_comp_in = (f_vin >= f_sw);
  assign swn       = ~sw;
  assign f_swn     = ~f_sw;

  sar_conv_ctrl u_dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .comp_in(comp_in),
    .comp_en(comp_en), .sample(sample), .sw(sw), .swb(swb), .result(result),
    .result_valid(result_valid), .result_ready(result_ready)
  );

  sar_conv_ctrl #(.SAMPLE_CYCLES(1), .SETTLE_CYCLES(0)) u_fast (
    .clk(clk), .rst(f_rst), .start(f_start), .busy(f_busy), .comp_in(f_comp_in),
    .comp_en(f_comp_en), .sample(f_sample), .sw(f_sw), .swb(f_swb), .result(f_result),
    .result_valid(f_valid), .result_ready(f_ready)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int n_comp = 0;
  int n_rise = 0;
  logic prev_valid = 1'b0;
  logic [5:0] exp_q[$];
  logic [5:0] trials[$];
  logic [5:0] tv [6] = '{6'h20, 6'h30, 6'h28, 6'h2C, 6'h2A, 6'h2B};
  int avg_seq [4] = '{40, 41, 41, 42};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Monitor: runs after the bench has driven inputs, so it sees what the next edge will see
  always begin
    @(negedge clk);
    #2;
    check("swb_inv", swb, swn);
    check("f_swb_inv", f_swb, f_swn);
    if (comp_en) begin
      n_comp++;
      trials.push_back(sw);
    end
    if (result_valid && !prev_valid) n_rise++;
    prev_valid = result_valid;
    if (result_valid && result_ready) begin
      if (exp_q.size() == 0) check("unexpected_result", 1, 0);
      else check("result", result, exp_q.pop_front());
    end
  end

  task automatic start_conv(input logic [5:0] v, input logic [5:0] e, output int c_acc);
    check("idle_before_start", busy, 0);
    vin   = v;
    start = 1'b1;
    exp_q.push_back(e);
    c_acc = cyc + 1;
    step();
    start = 1'b0;
    check("busy_after_accept", busy, 1);
    check("sample_after_accept", sample, 1);
  endtask

  task automatic wait_valid(input int c_acc, input int lat);
    int n = 0;
    while (!result_valid && n < 400) begin
      step();
      n++;
    end
    if (!result_valid) check("valid_timeout", 0, 1);
    else begin
      check("latency", cyc - c_acc, lat);
      check("busy_fall", busy, 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    int n;
    int r0;
    int k;
    int rises [3];
    logic prev_s;
    logic prev_f;

    rst = 1'b1; start = 1'b0; vin = '0; result_ready = 1'b1;
    f_rst = 1'b1; f_start = 1'b0; f_vin = 6'd17; f_ready = 1'b1;
    repeat (3) step();
    check("rst_busy", busy, 0);
    check("rst_sample", sample, 0);
    check("rst_comp_en", comp_en, 0);
    check("rst_sw", sw, 6'h00);
    check("rst_swb", swb, 6'h3F);
    check("rst_result", result, 6'h00);
    check("rst_valid", result_valid, 0);
    rst = 1'b0;
    f_rst = 1'b0;
    step();

    // Nominal conversion, vin = 42
    n_comp = 0;
    trials.delete();
    start_conv(6'd42, 6'h2A, c);
    wait_valid(c, CONV * L);
    check("code_42", result, 6'h2A);
    step();
    check("valid_one_cycle", result_valid, 0);
    check("comp_en_count", n_comp, 6 * CONV);
    for (int i = 0; i < 6; i++) begin
      if (trials.size() > i) check("sw_trial", trials[i], tv[i]);
      else check("sw_trial_missing", 0, 1);
    end

    // Range ends
    start_conv(6'd0, 6'h00, c);
    wait_valid(c, CONV * L);
    step();
    start_conv(6'd63, 6'h3F, c);
    wait_valid(c, CONV * L);
    step();

    // Back-pressure: first result held, second parks in HOLD
    result_ready = 1'b0;
    start_conv(6'd10, 6'd10, c);
    wait_valid(c, CONV * L);
    step();
    start_conv(6'd50, 6'd50, c);
    repeat (CONV * L + 2) begin
      check("held_result", result, 6'd10);
      check("held_valid", result_valid, 1);
      step();
    end
    check("hold_busy", busy, 1);
    check("hold_sw", sw, 6'h00);
    result_ready = 1'b1;
    step();
    check("second_loaded", result, 6'd50);
    check("second_valid", result_valid, 1);
    check("hold_released", busy, 0);
    step();
    check("second_accepted", result_valid, 0);

    // start pulsed while busy must be ignored
    r0 = n_rise;
    start_conv(6'd20, 6'd20, c);
    repeat (5) step();
    start = 1'b1;
    step();
    start = 1'b0;
    wait_valid(c, CONV * L);
    repeat (CONV * L + 5) step();
    check("single_result", n_rise - r0, 1);

    // Reset during COMPARE aborts immediately
    start_conv(6'd33, 6'd33, c);
    n = 0;
    while (!comp_en && n < 100) begin
      step();
      n++;
    end
    if (!comp_en) check("compare_timeout", 0, 1);
    rst = 1'b1;
    exp_q.delete();
    #1;
    check("arst_busy", busy, 0);
    check("arst_sample", sample, 0);
    check("arst_comp_en", comp_en, 0);
    check("arst_sw", sw, 6'h00);
    check("arst_swb", swb, 6'h3F);
    check("arst_result", result, 6'h00);
    check("arst_valid", result_valid, 0);
    step();
    step();
    rst = 1'b0;
    r0 = n_rise;
    repeat (30) step();
    check("no_result_after_reset", n_rise - r0, 0);
    check("idle_after_reset", busy, 0);

    // Fast instance, start held high: back-to-back results
    f_start = 1'b1;
    c = cyc + 1;
    k = 0;
    n = 0;
    prev_f = 1'b0;
    while (k < 3 && n < 300) begin
      step();
      n++;
      if (f_valid && !prev_f) begin
        rises[k] = cyc;
        check("fast_code", f_result, 6'd17);
        k++;
      end
      prev_f = f_valid;
    end
    f_start = 1'b0;
    if (k < 3) check("fast_timeout", k, 3);
    else begin
      check("fast_latency", rises[0] - c, CONV * LF);
      check("fast_period_1", rises[1] - rises[0], CONV * LF + 1);
      check("fast_period_2", rises[2] - rises[1], CONV * LF + 1);
    end
    repeat (CONV * LF + 4) step();

`ifdef SAR_CTRL_AVG_EN
    // Averaging: vin changes at each conversion's sample phase
    start_conv(6'd40, 6'h29, c);
    k = 1;
    n = 0;
    prev_s = sample;
    while (!result_valid && n < 400) begin
      step();
      n++;
      if (sample && !prev_s && k < 4) begin
        vin = 6'(avg_seq[k]);
        k++;
      end
      prev_s = sample;
    end
    if (!result_valid) check("avg_timeout", 0, 1);
    else begin
      check("avg_latency", cyc - c, 4 * L);
      check("avg_code", result, 6'h29);
    end
    step();
`endif

    check("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
